// File: rtl/dff_shift_pkg.sv
// -----------------------------------------------------------------------------
// dff_shift_pkg
//
// Shared definitions for the dff_shift_reg register bank / serialiser.
//   state_t    : control FSM encoding (IDLE, SHIFT)
//   DIR_LEFT   : shift left, MSB leaves first
//   DIR_RIGHT  : shift right, LSB leaves first
//   serial_out : helper selecting the outgoing serial bit from the two ends
// -----------------------------------------------------------------------------
package dff_shift_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Pick the bit currently leaving the register for the captured direction.
    function automatic logic serial_out(input logic dir_bit,
                                        input logic msb_bit,
                                        input logic lsb_bit);
        logic bit_s;
        if (dir_bit == DIR_RIGHT) begin
            bit_s = lsb_bit;
        end else begin
            bit_s = msb_bit;
        end
        return bit_s;
    endfunction

endpackage : dff_shift_pkg

// File: rtl/dff_cell.sv
// -----------------------------------------------------------------------------
// dff_cell
//
// One storage bit of the data bank: D flip-flop with clock enable and
// asynchronous active-low reset to 0.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   en    : clock enable, 0 holds the stored bit
//   d     : next data bit
//   q     : stored bit
// -----------------------------------------------------------------------------
module dff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);

    logic q_d;
    logic q_q;

    // Next value: take d when enabled, otherwise keep the stored bit.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // Storage flop with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : dff_cell

// File: rtl/dff_shift_reg.sv
// -----------------------------------------------------------------------------
// dff_shift_reg
//
// WIDTH-bit register bank with clock enable, parallel load and an automatic
// serialiser. A start request in IDLE loads d_par and captures dir; the block
// then shifts once per enabled clock for WIDTH shifts, filling the vacated end
// with d_ser, and pulses done after the last shift.
//
// Parameters:
//   WIDTH  : register width, 2..32
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   en     : clock enable; 0 freezes load, shift, counter and state
//   start  : load request, honoured only in IDLE with en=1
//   dir    : 0 = shift left (MSB first), 1 = shift right (LSB first)
//   d_par  : parallel load word
//   d_ser  : serial input bit
//   q      : register contents
//   q_ser  : current outgoing serial bit (combinational from registers)
//   busy   : high while a shift sequence is in progress
//   done   : one-cycle pulse after the WIDTH-th shift
//   qn     : ~q, present only when DFF_SHIFT_QN_EN is defined
//
// Build option: define DFF_SHIFT_QN_EN to add the complementary output qn.
// -----------------------------------------------------------------------------
module dff_shift_reg
    import dff_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] d_par,
    input  logic             d_ser,
    output logic [WIDTH-1:0] q,
    output logic             q_ser,
    output logic             busy,
    output logic             done
`ifdef DFF_SHIFT_QN_EN
    ,
    output logic [WIDTH-1:0] qn
`endif
);

    // Counter only ever needs to reach WIDTH-1.
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               dir_q;
    logic               dir_d;
    logic               done_q;
    logic               done_d;
    logic [WIDTH-1:0]   bank_q;
    logic [WIDTH-1:0]   bank_d;
    logic               bank_en;

    // Next-state, counter, direction, done and data-bank next value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        bank_d  = bank_q;
        bank_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && start) begin
                    bank_d  = d_par;
                    bank_en = 1'b1;
                    dir_d   = dir;
                    cnt_d   = CNT_ZERO;
                    state_d = SHIFT;
                end else begin
                    bank_en = 1'b0;
                end
            end
            SHIFT: begin
                // start is deliberately not looked at here: it is neither
                // queued nor flagged while a sequence is running.
                if (en) begin
                    bank_en = 1'b1;
                    if (dir_q == DIR_RIGHT) begin
                        bank_d = {d_ser, bank_q[WIDTH-1:1]};
                    end else begin
                        bank_d = {bank_q[WIDTH-2:0], d_ser};
                    end
                    if (cnt_q == CNT_LAST) begin
                        // Last shift: return the counter to its rest value
                        // rather than letting it wrap.
                        cnt_d   = CNT_ZERO;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end else begin
                    bank_en = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Control registers. done is not gated by en so the pulse lasts one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            dir_q   <= DIR_LEFT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Data bank: one enabled async-reset flop per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        dff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (bank_en),
            .d     (bank_d[i]),
            .q     (bank_q[i])
        );
    end

    assign q     = bank_q;
    assign q_ser = serial_out(dir_q, bank_q[WIDTH-1], bank_q[0]);
    assign busy  = (state_q == SHIFT);
    assign done  = done_q;

`ifdef DFF_SHIFT_QN_EN
    assign qn    = ~bank_q;
`endif

endmodule : dff_shift_reg

// File: tb/tb_dff_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_dff_shift_reg
//
// Scoreboard bench for dff_shift_reg (WIDTH=8). Each driven cycle pushes the
// reference model's expected outputs into a queue; the entry is popped and
// compared after the DUT has clocked. Directed checks add fixed constants for
// the serial sequences, stall, start handling and abort scenarios.
// Define DFF_SHIFT_QN_EN to also check qn.
// -----------------------------------------------------------------------------
module tb_dff_shift_reg;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] q;
        logic         qs;
        logic         busy;
        logic         done;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         start;
    logic         dir;
    logic [W-1:0] d_par;
    logic         d_ser;
    logic [W-1:0] q;
    logic         q_ser;
    logic         busy;
    logic         done;
`ifdef DFF_SHIFT_QN_EN
    logic [W-1:0] qn;
`endif

    exp_t         sb_q[$];
    int           total;
    int           bad;

    // reference model state
    logic [W-1:0] m_q;
    logic         m_dir;
    int           m_shifts;
    logic         m_busy;
    logic         m_done;

    // last observed outputs
    logic [W-1:0] obs_q;
    logic         obs_qs;
    logic         obs_busy;
    logic         obs_done;

    dff_shift_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .start (start),
        .dir   (dir),
        .d_par (d_par),
        .d_ser (d_ser),
        .q     (q),
        .q_ser (q_ser),
        .busy  (busy),
        .done  (done)
`ifdef DFF_SHIFT_QN_EN
        ,
        .qn    (qn)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q      = '0;
        m_dir    = 1'b0;
        m_shifts = 0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
    endtask

    task automatic model_step(input logic t_en, input logic t_start, input logic t_dir,
                              input logic [W-1:0] t_par, input logic t_ser);
        logic nd;
        nd = 1'b0;
        if (!m_busy) begin
            if (t_en && t_start) begin
                m_q      = t_par;
                m_dir    = t_dir;
                m_shifts = 0;
                m_busy   = 1'b1;
            end
        end else if (t_en) begin
            if (m_dir) m_q = {t_ser, m_q[W-1:1]};
            else       m_q = {m_q[W-2:0], t_ser};
            m_shifts++;
            if (m_shifts == W) begin
                m_busy = 1'b0;
                nd     = 1'b1;
            end
        end
        m_done = nd;
    endtask

    // One clock: drive, model, push expectation, then pop and compare.
    task automatic tick(input logic t_en, input logic t_start, input logic t_dir,
                        input logic [W-1:0] t_par, input logic t_ser);
        exp_t e;
        exp_t x;
        en    = t_en;
        start = t_start;
        dir   = t_dir;
        d_par = t_par;
        d_ser = t_ser;
        @(posedge clk);
        model_step(t_en, t_start, t_dir, t_par, t_ser);
        e.q    = m_q;
        e.qs   = m_dir ? m_q[0] : m_q[W-1];
        e.busy = m_busy;
        e.done = m_done;
        sb_q.push_back(e);
        @(negedge clk);
        x = sb_q.pop_front();
        check_val("sb_q",    32'(q),     32'(x.q));
        check_val("sb_qser", 32'(q_ser), 32'(x.qs));
        check_val("sb_busy", 32'(busy),  32'(x.busy));
        check_val("sb_done", 32'(done),  32'(x.done));
`ifdef DFF_SHIFT_QN_EN
        check_val("sb_qn",   32'(qn),    32'(~x.q));
`endif
        obs_q    = q;
        obs_qs   = q_ser;
        obs_busy = busy;
        obs_done = done;
    endtask

    // Assert reset in the middle of the low clock phase and check at once.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        sb_q.delete();
        check_val("rst_q",    32'(q),     32'h0);
        check_val("rst_busy", 32'(busy),  32'h0);
        check_val("rst_done", 32'(done),  32'h0);
        check_val("rst_qser", 32'(q_ser), 32'h0);
`ifdef DFF_SHIFT_QN_EN
        check_val("rst_qn",   32'(qn),    32'hFF);
`endif
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] a5_bits;
        int         done_cnt;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        start = 1'b0;
        dir   = 1'b0;
        d_par = '0;
        d_ser = 1'b0;
        model_reset();
        a5_bits = 8'hA5;

        // Reset state
        repeat (2) @(negedge clk);
        mid_reset();

        // MSB-first 0xA5, d_ser=0
        tick(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);
        check_val("msb_load_q", 32'(obs_q), 32'hA5);
        check_val("msb_busy0",  32'(obs_busy), 32'h1);
        for (int k = 0; k < 8; k++) begin
            check_val("msb_qser", 32'(obs_qs), 32'(a5_bits[7-k]));
            check_val("msb_nodone", 32'(obs_done), 32'h0);
            tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        check_val("msb_done",  32'(obs_done), 32'h1);
        check_val("msb_final", 32'(obs_q),    32'h00);
        check_val("msb_idle",  32'(obs_busy), 32'h0);
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check_val("msb_done_clr", 32'(obs_done), 32'h0);

        // LSB-first 0x01, d_ser=1
        tick(1'b1, 1'b1, 1'b1, 8'h01, 1'b1);
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            check_val("lsb_qser", 32'(obs_qs), (k == 0) ? 32'h1 : 32'h0);
            tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            if (obs_done) done_cnt++;
        end
        check_val("lsb_final", 32'(obs_q), 32'hFF);
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        if (obs_done) done_cnt++;
        check_val("lsb_done_cnt", 32'(done_cnt), 32'h1);

        // Stall: 3 disabled cycles after E2
        tick(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 1'b0, 8'hFF, 1'b1);
            check_val("stall_q",    32'(obs_q),  32'h94);
            check_val("stall_qser", 32'(obs_qs), 32'h1);
        end
        for (int k = 6; k <= 11; k++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            check_val("stall_done", 32'(obs_done), (k == 11) ? 32'h1 : 32'h0);
        end
        check_val("stall_final", 32'(obs_q), 32'h00);

        // start during busy is ignored; start in done cycle loads at once
        tick(1'b1, 1'b1, 1'b0, 8'hA5, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, (k == 3 || k == 4), 1'b1, 8'h00, 1'b1);
        end
        check_val("ign_done", 32'(obs_done), 32'h1);
        check_val("ign_busy", 32'(obs_busy), 32'h0);
        check_val("ign_q",    32'(obs_q),    32'hFF);
        tick(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0);
        check_val("b2b_busy", 32'(obs_busy), 32'h1);
        check_val("b2b_q",    32'(obs_q),    32'h3C);
        check_val("b2b_done", 32'(obs_done), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        end
        check_val("b2b_final", 32'(obs_q),    32'h00);
        check_val("b2b_fdone", 32'(obs_done), 32'h1);

        // Abort after 4 shifts
        tick(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        end
        check_val("abort_pre_q", 32'(obs_q), 32'h05);
        mid_reset();
        done_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            if (obs_done) done_cnt++;
        end
        check_val("abort_nodone", 32'(done_cnt), 32'h0);
        tick(1'b1, 1'b1, 1'b1, 8'h81, 1'b1);
        check_val("abort_restart", 32'(obs_busy), 32'h1);
        for (int k = 0; k < 8; k++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        check_val("abort_final", 32'(obs_q),    32'hFF);
        check_val("abort_done",  32'(obs_done), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dff_shift_reg

// File: doc/dff_shift_reg.md
# dff_shift_reg

Parametrised successor to the single D flip-flop: a WIDTH-bit register bank of async-reset flops with clock enable, parallel load and an automatic serialiser. A start request loads a parallel word, then the block shifts it out one bit per enabled clock, MSB-first or LSB-first, while shifting serial input in. It serves as the general storage/serialising element for the flop-level test designs.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32
- CNT_W, $clog2(WIDTH), shift-counter width; derived, not overridden
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  clock enable; 0 freezes load, shift, counter and state
- start  input  1  load request, sampled at the rising edge while idle and en=1
- dir  input  1  0 = shift left (MSB out first), 1 = shift right (LSB out first); captured at start
- d_par  input  WIDTH  parallel load word
- d_ser  input  1  serial input bit, shifted into the vacated end
- q  output  WIDTH  register contents
- q_ser  output  1  current serial output bit: q[WIDTH-1] if captured dir=0, q[0] if dir=1; combinational from registers
- busy  output  1  high while a shift sequence is in progress
- done  output  1  one-cycle pulse on completion of the WIDTH-th shift
- qn  output  WIDTH  bitwise complement of q (only with DFF_SHIFT_QN_EN)

## Operation
- Two states: IDLE, SHIFT.
- IDLE, en=1, start=1: q <= d_par, dir_r <= dir, cnt <= 0, go to SHIFT.
- IDLE otherwise: q holds.
- SHIFT, en=1:
  - dir_r=0: q <= {q[WIDTH-2:0], d_ser}
  - dir_r=1: q <= {d_ser, q[WIDTH-1:1]}
  - cnt <= cnt+1
  - When cnt==WIDTH-1, this is the last shift: go to IDLE, done <= 1.
- SHIFT, en=0: all registers hold.
- start in SHIFT is ignored; it is neither queued nor an error.
- done is cleared at the next rising edge regardless of en.
- busy = (state==SHIFT).
- The counter never exceeds WIDTH-1; there is no wrap.

## Timing
- Reset, asynchronous on the falling edge of rst_n:
  - q=0, dir_r=0, cnt=0, state=IDLE, busy=0, done=0
  - q_ser=0, qn=all ones
- Reset asserted mid-shift aborts the sequence. No done pulse follows.
- Reset deassertion is synchronous to clk. The first start can be accepted at the first edge with rst_n high.
- Start accepted at edge E0:
  - q=d_par and busy=1 after E0.
  - q_ser presents the first bit during the cycle after E0.
  - Shifts occur at edges E1..E_WIDTH, when en=1 throughout.
  - After E_WIDTH: busy=0 and done=1 for exactly one cycle.
- Each cycle with en=0 during SHIFT delays completion by one edge.
- Back-to-back sequences: a start sampled in the done cycle (state IDLE) is accepted, so busy deasserts for exactly one cycle.

## Configuration
- DFF_SHIFT_QN_EN defined:
  - qn port present, qn = ~q, mirroring the complementary output of the original flop.
  - Reset value of qn is all ones.
- DFF_SHIFT_QN_EN undefined:
  - qn port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package dff_shift_pkg contains:
  - state enum (IDLE, SHIFT)
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1 constants
- Sub-module dff_cell holds one bit:
  - async active-low reset to 0, enable, d/q
  - instantiated WIDTH times via generate for the data bank
- Control state, counter and dir_r live in the top module.

## Test plan
- Reset: hold rst_n=0 mid-clock -> q=0x00, busy=0, done=0, q_ser=0, qn=0xFF with macro defined.
- MSB-first: WIDTH=8, dir=0, d_par=0xA5, d_ser=0 -> q_ser sequence over cycles after E0..E7 is 1,0,1,0,0,1,0,1; done at E8 only; final q=0x00.
- LSB-first: dir=1, d_par=0x01, d_ser=1 -> q_ser sequence 1,0,0,0,0,0,0,0; final q=0xFF; done one cycle.
- Stall: 0xA5 MSB-first with en=0 for 3 cycles after E2 -> q and q_ser frozen during the stall; done asserted after E11 instead of E8.
- Start handling:
  - start pulsed during busy -> ignored; the sequence completes unchanged.
  - start held in the done cycle with d_par=0x3C -> loaded immediately; busy low for one cycle, then high.
- Abort: rst_n=0 after 4 shifts -> immediately q=0, busy=0; no done pulse; the next start works normally.
